// File: rtl/axi_pkg.sv
// Shared AXI arbitration types and helpers.
// Used by the write-side arbiter and its round-robin picker.
package axi_pkg;

  localparam int AXI_RESP_W = 2;
  localparam int AXI_LEN_W  = 8;
  localparam int BEAT_W     = AXI_LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } arb_state_e;

  // Beat counter saturates at 256 so a runaway burst cannot wrap.
  function automatic logic [BEAT_W-1:0] beat_inc(
    input logic [BEAT_W-1:0] c
  );
    return (c == BEAT_W'(256)) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester at or after ptr, wrapping around.
module axi_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    // Walk backwards so the nearest requester wins last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[IW'((int'(ptr) + i) % N)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/axi_wr_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write port among NUM_MST masters.
// One transaction in flight; grant held from AW through B; W length check.
module axi_wr_rr_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int GW      = $clog2(NUM_MST),
  parameter int STRB_W  = DATA_W / 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_MST-1:0]          s_awvalid,
  output logic [NUM_MST-1:0]          s_awready,
  input  logic [NUM_MST*ADDR_W-1:0]   s_awaddr,
  input  logic [NUM_MST*8-1:0]        s_awlen,
  input  logic [NUM_MST*ID_W-1:0]     s_awid,
  input  logic [NUM_MST-1:0]          s_wvalid,
  output logic [NUM_MST-1:0]          s_wready,
  input  logic [NUM_MST*DATA_W-1:0]   s_wdata,
  input  logic [NUM_MST*STRB_W-1:0]   s_wstrb,
  input  logic [NUM_MST-1:0]          s_wlast,
  output logic [NUM_MST-1:0]          s_bvalid,
  input  logic [NUM_MST-1:0]          s_bready,
  output logic [AXI_RESP_W-1:0]       s_bresp,
  output logic [ID_W-1:0]             s_bid,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [ADDR_W-1:0]           m_awaddr,
  output logic [7:0]                  m_awlen,
  output logic [ID_W-1:0]             m_awid,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  output logic [DATA_W-1:0]           m_wdata,
  output logic [STRB_W-1:0]           m_wstrb,
  output logic                        m_wlast,
  input  logic                        m_bvalid,
  output logic                        m_bready,
  input  logic [AXI_RESP_W-1:0]       m_bresp,
  input  logic [ID_W-1:0]             m_bid,
  output logic [GW-1:0]               grant_idx,
  output logic                        busy,
  output logic                        len_err
);

  arb_state_e state_q, state_d;

  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        ptr_q;
  logic [GW-1:0]        next_ptr;
  logic [AXI_LEN_W-1:0] awlen_q;
  logic [BEAT_W-1:0]    beats_q;
  logic [BEAT_W-1:0]    beats_inc;
  logic                 len_err_q;

  logic [GW-1:0]        pick_idx;
  logic                 pick_any;
  logic [NUM_MST-1:0]   onehot;

  logic in_addr, in_data, in_resp;
  logic aw_hs, w_hs, b_hs;

  logic [ADDR_W-1:0] awaddr_a [NUM_MST];
  logic [7:0]        awlen_a  [NUM_MST];
  logic [ID_W-1:0]   awid_a   [NUM_MST];
  logic [DATA_W-1:0] wdata_a  [NUM_MST];
  logic [STRB_W-1:0] wstrb_a  [NUM_MST];

  for (genvar i = 0; i < NUM_MST; i++) begin : g_unpack
    assign awaddr_a[i] = s_awaddr[i*ADDR_W +: ADDR_W];
    assign awlen_a[i]  = s_awlen[i*8 +: 8];
    assign awid_a[i]   = s_awid[i*ID_W +: ID_W];
    assign wdata_a[i]  = s_wdata[i*DATA_W +: DATA_W];
    assign wstrb_a[i]  = s_wstrb[i*STRB_W +: STRB_W];
  end

  axi_rr_pick #(
    .N  (NUM_MST),
    .IW (GW)
  ) u_pick (
    .req     (s_awvalid),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  assign in_resp = (state_q == RESP);
  assign onehot  = NUM_MST'(1) << grant_q;

  assign m_awvalid = in_addr & s_awvalid[grant_q];
  assign m_awaddr  = awaddr_a[grant_q];
  assign m_awlen   = awlen_a[grant_q];
  assign m_awid    = awid_a[grant_q];

  assign m_wvalid = in_data & s_wvalid[grant_q];
  assign m_wdata  = wdata_a[grant_q];
  assign m_wstrb  = wstrb_a[grant_q];
  assign m_wlast  = s_wlast[grant_q];

  assign m_bready = in_resp & s_bready[grant_q];
  assign s_bresp  = m_bresp;
  assign s_bid    = m_bid;

  assign s_awready = onehot & {NUM_MST{in_addr & m_awready}};
  assign s_wready  = onehot & {NUM_MST{in_data & m_wready}};
  assign s_bvalid  = onehot & {NUM_MST{in_resp & m_bvalid}};

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;
  assign b_hs  = m_bvalid & m_bready;

  assign beats_inc = beat_inc(beats_q);
  assign next_ptr  = (grant_q == GW'(NUM_MST - 1)) ? '0
                   : grant_q + 1'b1;

  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);
  assign len_err   = len_err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = ADDR;
      ADDR:    if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && m_wlast) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      awlen_q   <= '0;
      beats_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_err_q <= 1'b0;
      if (state_q == IDLE && pick_any) grant_q <= pick_idx;
      if (aw_hs) begin
        awlen_q <= m_awlen;
        beats_q <= '0;
      end
      if (w_hs) begin
        beats_q <= beats_inc;
        // Compare 9-bit so awlen=255 (256 beats) is representable.
        if (m_wlast)
          len_err_q <= (beats_inc != ({1'b0, awlen_q} + 1'b1));
      end
      if (b_hs) ptr_q <= next_ptr;
    end
  end

endmodule

// File: tb/tb_axi_wr_rr_arbiter.sv
// Bench for axi_wr_rr_arbiter: master/slave models with a
// scoreboard of expected downstream transactions in service order.
module tb_axi_wr_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  logic            aclk;
  logic            aresetn;
  logic [N-1:0]    s_awvalid, s_awready;
  logic [N*AW-1:0] s_awaddr;
  logic [N*8-1:0]  s_awlen;
  logic [N*IW-1:0] s_awid;
  logic [N-1:0]    s_wvalid, s_wready;
  logic [N*DW-1:0] s_wdata;
  logic [N*SW-1:0] s_wstrb;
  logic [N-1:0]    s_wlast;
  logic [N-1:0]    s_bvalid, s_bready;
  logic [1:0]      s_bresp;
  logic [IW-1:0]   s_bid;
  logic            m_awvalid, m_awready;
  logic [AW-1:0]   m_awaddr;
  logic [7:0]      m_awlen;
  logic [IW-1:0]   m_awid;
  logic            m_wvalid, m_wready;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_wlast;
  logic            m_bvalid, m_bready;
  logic [1:0]      m_bresp;
  logic [IW-1:0]   m_bid;
  logic [1:0]      grant_idx;
  logic            busy;
  logic            len_err;

  axi_wr_rr_arbiter #(
    .NUM_MST (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ID_W    (IW)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awaddr  (s_awaddr),
    .s_awlen   (s_awlen),
    .s_awid    (s_awid),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wlast   (s_wlast),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_bresp   (s_bresp),
    .s_bid     (s_bid),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_awaddr  (m_awaddr),
    .m_awlen   (m_awlen),
    .m_awid    (m_awid),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wlast   (m_wlast),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_bresp   (m_bresp),
    .m_bid     (m_bid),
    .grant_idx (grant_idx),
    .busy      (busy),
    .len_err   (len_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    int         mst;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    int          nbeats;
    logic [1:0]  resp;
  } txn_t;

  txn_t mq [N][$];
  txn_t exp_q [$];
  txn_t cur;
  bit   cur_v;
  int   dbeat;
  bit   aw_done [N];
  int   wb [N];
  bit   b_pend;
  int   b_dly, aw_st, w_st;
  bit   stall_en;
  bit   le_exp, idle_exp;
  int   le_cnt;
  int   checks, errors;

  function automatic logic [31:0] wd(input logic [31:0] a, input int b);
    logic [31:0] k;
    k = 32'(b + 1);
    return a ^ (k * 32'h9e37_79b9);
  endfunction

  function automatic logic [3:0] ws(input int b);
    return 4'((b % 15) + 1);
  endfunction

  function automatic int rnd_stall();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  function automatic bit all_done();
    bit d;
    d = (exp_q.size() == 0) && !cur_v;
    for (int i = 0; i < N; i++)
      if (mq[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic add(input int m, input logic [31:0] a,
                     input logic [7:0] l, input int nb,
                     input logic [1:0] r);
    txn_t t;
    t.mst = m; t.addr = a; t.len = l;
    t.id = 4'(m) ^ a[11:8];
    t.nbeats = nb; t.resp = r;
    mq[m].push_back(t);
    exp_q.push_back(t);
  endtask

  task automatic clear_models();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      aw_done[i] = 1'b0;
      wb[i] = 0;
    end
    exp_q.delete();
    cur_v = 1'b0; dbeat = 0; b_pend = 1'b0;
    b_dly = 0; aw_st = 0; w_st = 0;
    le_exp = 1'b0; idle_exp = 1'b0;
  endtask

  task automatic drive();
    txn_t t;
    s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_awid = '0;
    s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
    s_bready = '0;
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() > 0) begin
        t = mq[i][0];
        s_awvalid[i]          = !aw_done[i];
        s_awaddr[i*AW +: AW]  = t.addr;
        s_awlen[i*8 +: 8]     = t.len;
        s_awid[i*IW +: IW]    = t.id;
        s_wvalid[i]           = (wb[i] < t.nbeats);
        s_wdata[i*DW +: DW]   = wd(t.addr, wb[i]);
        s_wstrb[i*SW +: SW]   = ws(wb[i]);
        s_wlast[i]            = (wb[i] == t.nbeats - 1);
        s_bready[i]           = 1'b1;
      end
    end
    m_awready = (aw_st == 0);
    m_wready  = (w_st == 0);
    m_bvalid  = b_pend && (b_dly == 0);
    m_bresp   = cur.resp;
    m_bid     = cur.id;
  endtask

  task automatic step();
    logic [N-1:0] mask;
    @(negedge aclk);
    drive();
    #1;
    checks++;
    if (len_err !== le_exp) begin
      errors++;
      $display("FAIL len_err got=%b exp=%b t=%0t", len_err, le_exp, $time);
    end
    if (len_err === 1'b1) le_cnt++;
    le_exp = 1'b0;
    if (idle_exp) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_b busy got=%b exp=0", busy);
      end
      idle_exp = 1'b0;
    end
    mask = ~(N'(1) << grant_idx);
    checks++;
    if (((s_awready | s_wready | s_bvalid) & mask) !== '0) begin
      errors++;
      $display("FAIL non_granted aw=%b w=%b b=%b grant=%0d exp=0",
               s_awready, s_wready, s_bvalid, grant_idx);
    end
    if (m_awvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_aw addr=%h exp=none", m_awaddr);
      end else if (m_awaddr !== exp_q[0].addr || m_awlen !== exp_q[0].len ||
                   m_awid !== exp_q[0].id ||
                   grant_idx !== 2'(exp_q[0].mst)) begin
        errors++;
        $display("FAIL aw_fields addr=%h/%h len=%0d/%0d id=%h/%h grant=%0d/%0d",
                 m_awaddr, exp_q[0].addr, m_awlen, exp_q[0].len,
                 m_awid, exp_q[0].id, grant_idx, exp_q[0].mst);
      end
      if (m_awready) begin
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          cur_v = 1'b1;
        end
        dbeat = 0;
        aw_st = rnd_stall();
      end else if (aw_st > 0) aw_st--;
    end
    if (m_wvalid) begin
      checks++;
      if (!cur_v || dbeat >= cur.nbeats) begin
        errors++;
        $display("FAIL unexpected_w beat=%0d exp_max=%0d", dbeat, cur.nbeats);
      end else if (m_wdata !== wd(cur.addr, dbeat) || m_wstrb !== ws(dbeat) ||
                   m_wlast !== (dbeat == cur.nbeats - 1)) begin
        errors++;
        $display("FAIL w_beat%0d data=%h/%h strb=%h/%h last=%b",
                 dbeat, m_wdata, wd(cur.addr, dbeat), m_wstrb, ws(dbeat),
                 m_wlast);
      end
      if (m_wready) begin
        if (m_wlast) begin
          b_pend = 1'b1;
          b_dly = rnd_stall();
          le_exp = ((dbeat + 1) != (int'(cur.len) + 1));
        end
        dbeat++;
        w_st = rnd_stall();
      end else if (w_st > 0) w_st--;
    end
    if (m_bvalid && m_bready) begin
      checks++;
      if (s_bvalid !== (N'(1) << cur.mst) || s_bresp !== cur.resp ||
          s_bid !== cur.id || dbeat != cur.nbeats) begin
        errors++;
        $display("FAIL b_resp bvalid=%b/%b resp=%0d/%0d id=%h/%h beats=%0d/%0d",
                 s_bvalid, N'(1) << cur.mst, s_bresp, cur.resp,
                 s_bid, cur.id, dbeat, cur.nbeats);
      end
      b_pend = 1'b0;
      cur_v = 1'b0;
      idle_exp = 1'b1;
    end else if (b_pend && b_dly > 0) b_dly--;
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() > 0) begin
        if (s_awvalid[i] && s_awready[i]) aw_done[i] = 1'b1;
        if (s_wvalid[i] && s_wready[i]) wb[i]++;
        if (s_bvalid[i] && s_bready[i]) begin
          void'(mq[i].pop_front());
          aw_done[i] = 1'b0;
          wb[i] = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_models();
    drive();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic run(input int max_cyc, input string name);
    int c;
    c = 0;
    while (!all_done() && c < max_cyc) begin
      step();
      c++;
    end
    checks++;
    if (!all_done()) begin
      errors++;
      $display("FAIL timeout_%s left=%0d exp=0", name, exp_q.size());
      do_reset();
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    clear_models();
    drive();
    #1;
    checks++;
    if (busy !== 1'b0 || len_err !== 1'b0 || grant_idx !== 2'd0 ||
        s_awready !== '0 || s_wready !== '0 || s_bvalid !== '0 ||
        m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b grant=%0d awv=%b wv=%b br=%b exp=0",
               busy, grant_idx, m_awvalid, m_wvalid, m_bready);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL idle_no_req busy=%b grant=%0d exp=0/0", busy, grant_idx);
    end
  endtask

  task automatic test_single();
    int l0;
    do_reset();
    l0 = le_cnt;
    add(1, 32'h1000_0100, 8'd3, 4, 2'b00);
    run(200, "single");
    checks++;
    if (le_cnt != l0) begin
      errors++;
      $display("FAIL single_len_err pulses=%0d exp=0", le_cnt - l0);
    end
  endtask

  task automatic test_three_way();
    do_reset();
    add(0, 32'h2000_0000, 8'd1, 2, 2'b00);
    add(2, 32'h2000_0200, 8'd0, 1, 2'b01);
    add(3, 32'h2000_0300, 8'd2, 3, 2'b00);
    run(300, "three_way");
    add(1, 32'h2100_0100, 8'd0, 1, 2'b00);
    add(3, 32'h2100_0300, 8'd0, 1, 2'b00);
    run(300, "ptr_wrap");
  endtask

  task automatic test_fair();
    do_reset();
    add(0, 32'h3000_0000, 8'd1, 2, 2'b00);
    add(1, 32'h3000_0100, 8'd1, 2, 2'b00);
    add(0, 32'h3000_1000, 8'd0, 1, 2'b10);
    add(1, 32'h3000_1100, 8'd2, 3, 2'b00);
    run(400, "fair");
  endtask

  task automatic test_len_mismatch();
    int l0;
    do_reset();
    l0 = le_cnt;
    add(2, 32'h4000_0200, 8'd3, 2, 2'b10);
    run(200, "early_last");
    checks++;
    if (le_cnt != l0 + 1) begin
      errors++;
      $display("FAIL early_len_err pulses=%0d exp=1", le_cnt - l0);
    end
    add(3, 32'h4000_0300, 8'd1, 3, 2'b00);
    run(200, "late_last");
    checks++;
    if (le_cnt != l0 + 2) begin
      errors++;
      $display("FAIL late_len_err pulses=%0d exp=2", le_cnt - l0);
    end
  endtask

  task automatic test_stall();
    int l;
    do_reset();
    stall_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      l = int'($urandom_range(0, 7));
      add(k % N, 32'h5000_0000 + 32'(k * 64), 8'(l), l + 1, 2'(k));
      run(1000, "stall");
    end
    stall_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset();
    add(2, 32'h6000_0200, 8'd7, 8, 2'b00);
    c = 0;
    while (!(cur_v && dbeat >= 3) && c < 200) begin
      step();
      c++;
    end
    checks++;
    if (!(cur_v && dbeat >= 3)) begin
      errors++;
      $display("FAIL reach_data beats=%0d exp>=3", dbeat);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (s_awready !== '0 || s_wready !== '0 || s_bvalid !== '0 ||
        m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b0 ||
        busy !== 1'b0 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL async_reset wr=%b wv=%b busy=%b grant=%0d exp=0",
               s_wready, m_wvalid, busy, grant_idx);
    end
    clear_models();
    drive();
    @(negedge aclk);
    aresetn = 1'b1;
    step();
    checks++;
    if (grant_idx !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset grant=%0d busy=%b exp=0/0", grant_idx, busy);
    end
    add(0, 32'h6100_0000, 8'd0, 1, 2'b00);
    add(3, 32'h6100_0300, 8'd0, 1, 2'b00);
    run(300, "post_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    le_cnt = 0;
    stall_en = 1'b0;
    cur = '{mst: 0, addr: '0, len: '0, id: '0, nbeats: 0, resp: '0};
    test_reset();
    test_single();
    test_three_way();
    test_fair();
    test_len_mismatch();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
